alu_mc: RTL
===========

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width; legal values are powers of two from 8 to 64.
REQ-002 Parameter SHW, default $clog2(WIDTH): shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operation request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 src_a  input  WIDTH  operand A.
REQ-008 src_b  input  WIDTH  operand B; shift amount is src_b[SHW-1:0].
REQ-009 alu_control  input  4  opcode.
REQ-010 out_valid  output  1  one-cycle pulse: result ready.
REQ-011 alu_result  output  WIDTH  registered result.
REQ-012 zero  output  1  high when alu_result == 0, registered with it.

Function
REQ-013 Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 sll, 0101 slt (signed), 0110 srl, 0111 sra, 1000 xor, 1001 sltu, 1010 mul (low WIDTH bits of the product); all other opcodes produce a result of 0.
REQ-014 Add/sub wrap modulo 2^WIDTH; there is no carry or overflow output.
REQ-015 slt/sltu return 1 in bit 0 and 0 elsewhere when A<B (signed/unsigned), else all zeros.
REQ-016 FSM states: IDLE, BUSY, DONE; in_ready = (state != BUSY).
REQ-017 Accept occurs when in_valid && in_ready; operands and opcode are captured at accept and later input changes have no effect.
REQ-018 Single-cycle ops (add, sub, and, or, xor, slt, sltu, undefined) go to DONE; out_valid is high in the cycle after accept (latency 1).
REQ-019 Shifts are iterative, one bit per cycle, with a down-counter loaded with shamt.
- shamt = 0: go directly to DONE (latency 1).
- Otherwise: BUSY for shamt cycles, then DONE (latency shamt+1).
REQ-020 sra replicates the captured sign bit; srl and sll fill with 0.
REQ-021 mul is iterative shift-add, one multiplier bit per cycle, with BUSY for exactly WIDTH cycles (latency WIDTH+1) regardless of operand values.
REQ-022 out_valid is high only in DONE, for exactly one cycle, unless a new accept happens in DONE.
REQ-023 An accept in DONE is legal and starts the next operation with no idle bubble: the next state is DONE or BUSY per REQ-018 to REQ-021.
REQ-024 DONE with no accept returns to IDLE.
REQ-025 in_valid during BUSY is ignored (in_ready=0); the requester holds its request.
REQ-026 alu_result and zero hold their last value until the next out_valid cycle, when both update together.

Reset
REQ-027 While reset is sampled high: state=IDLE, counter=0, out_valid=0, alu_result=0, zero=1, in_ready=1 in the following cycle.
REQ-028 Reset during BUSY aborts the operation: no out_valid is produced for it, and no partial result appears on alu_result.
REQ-029 Reset has priority over a simultaneous accept; that request is dropped.

Configuration
REQ-030 Macro ALU_MC_MUL_EN.
- Defined: the multiplier datapath and mul opcode are built per REQ-021.
- Undefined: no multiplier logic is built; opcode 1010 behaves as undefined (result 0, latency 1).

Verification
REQ-031 Reset, then add A=0x7FFFFFFF, B=1 -> out_valid 1 cycle after accept, result 0x80000000, zero=0; sub A=5, B=5 -> result 0, zero=1.
REQ-032 sra A=0x80000000, B=31 -> in_ready low for 31 cycles, out_valid at accept+32, result 0xFFFFFFFF; sll with shamt 0 -> latency 1, result = A.
REQ-033 slt A=0xFFFFFFFF, B=1 -> 1; sltu with the same operands -> 0; back-to-back accepts in DONE give consecutive out_valid pulses with no gap.
REQ-034 With ALU_MC_MUL_EN defined: mul A=0xFFFFFFFF, B=0xFFFFFFFF -> out_valid at accept+33, result 0x00000001; with the macro undefined: result 0 at accept+1.
REQ-035 Reset asserted mid-mul at accept+10 -> no out_valid, alu_result=0, in_ready=1 the cycle after reset is released; a new add then completes normally.
REQ-036 WIDTH=8: srl A=0x80, B=0xFF (shamt 7) -> out_valid at accept+8, result 0x01; changing src_a during BUSY does not change the result.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc -- multi-cycle ALU with a valid/ready request side and a one-cycle
// out_valid pulse on the result side.
//
// Single-cycle ops (add, sub, and, or, xor, slt, sltu, undefined) finish in
// one cycle. Shifts step one bit per cycle under a down-counter loaded with
// the shift amount. The optional multiplier is a shift-add loop running
// exactly WIDTH cycles. Operands are captured at accept. alu_result/zero
// only change in the cycle where out_valid is high.
//
// Build option: define ALU_MC_MUL_EN to build the multiplier (opcode 1010).
// Without it, 1010 behaves like any undefined opcode (result 0, latency 1).
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   synchronous active-high reset
//   in_valid     in   operation request
//   in_ready     out  request can be accepted this cycle
//   src_a/src_b  in   operands (shift amount = src_b[SHW-1:0])
//   alu_control  in   4-bit opcode
//   out_valid    out  one-cycle pulse, result ready
//   alu_result   out  registered result
//   zero         out  alu_result == 0, registered with it
module alu_mc #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_control,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero
);

  // One extra counter bit so the multiplier can load the value WIDTH.
  localparam int CW = SHW + 1;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_XOR  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;
`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_in_ready;
  logic             r_out_valid;
  logic             r_zero;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_acc;
  logic [3:0]       r_op;
  logic [CW-1:0]    r_cnt;
`ifdef ALU_MC_MUL_EN
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
`endif

  logic             w_accept;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_single;
  logic             w_start_busy;
  logic [WIDTH-1:0] w_load_acc;
  logic [CW-1:0]    w_load_cnt;
  logic [WIDTH-1:0] w_step;

  function automatic logic is_zero(input logic [WIDTH-1:0] v);
    return (v == {WIDTH{1'b0}});
  endfunction

  assign w_accept   = in_valid & r_in_ready;
  assign w_shamt    = src_b[SHW-1:0];
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign alu_result = r_result;
  assign zero       = r_zero;

  // Decode the incoming opcode: single-cycle result, or the loop start values.
  always_comb begin
    w_single     = {WIDTH{1'b0}};
    w_start_busy = 1'b0;
    w_load_acc   = src_a;
    w_load_cnt   = {1'b0, w_shamt};
    case (alu_control)
      OP_ADD:  w_single = src_a + src_b;
      OP_SUB:  w_single = src_a - src_b;
      OP_AND:  w_single = src_a & src_b;
      OP_OR:   w_single = src_a | src_b;
      OP_XOR:  w_single = src_a ^ src_b;
      OP_SLT:  w_single = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      OP_SLTU: w_single = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
      OP_SLL, OP_SRL, OP_SRA: begin
        // A zero shift amount completes immediately with the operand itself.
        w_single     = src_a;
        w_start_busy = (w_shamt != {SHW{1'b0}});
      end
`ifdef ALU_MC_MUL_EN
      OP_MUL: begin
        w_start_busy = 1'b1;
        w_load_acc   = {WIDTH{1'b0}};
        w_load_cnt   = CW'(WIDTH);
      end
`endif
      default: w_single = {WIDTH{1'b0}};
    endcase
  end

  // One iteration of the captured multi-cycle operation.
  always_comb begin
    w_step = r_acc;
    case (r_op)
      OP_SLL:  w_step = {r_acc[WIDTH-2:0], 1'b0};
      OP_SRL:  w_step = {1'b0, r_acc[WIDTH-1:1]};
      OP_SRA:  w_step = {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
`ifdef ALU_MC_MUL_EN
      OP_MUL:  w_step = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});
`endif
      default: w_step = r_acc;
    endcase
  end

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= {WIDTH{1'b0}};
      r_zero      <= 1'b1;
      r_acc       <= {WIDTH{1'b0}};
      r_op        <= 4'b0000;
      r_cnt       <= {CW{1'b0}};
`ifdef ALU_MC_MUL_EN
      r_mcand     <= {WIDTH{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
`endif
    end else if (w_accept) begin
      // Accept from IDLE or DONE; back-to-back accepts in DONE need no bubble.
      r_op <= alu_control;
`ifdef ALU_MC_MUL_EN
      r_mcand  <= src_a;
      r_mplier <= src_b;
`endif
      if (w_start_busy) begin
        r_state     <= BUSY;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
        r_acc       <= w_load_acc;
        r_cnt       <= w_load_cnt;
      end else begin
        r_state     <= DONE;
        r_in_ready  <= 1'b1;
        r_out_valid <= 1'b1;
        r_result    <= w_single;
        r_zero      <= is_zero(w_single);
        r_cnt       <= {CW{1'b0}};
      end
    end else begin
      case (r_state)
        BUSY: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
`ifdef ALU_MC_MUL_EN
          r_mcand  <= {r_mcand[WIDTH-2:0], 1'b0};
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
`endif
          // The last iteration writes straight into the visible result.
          if (r_cnt <= CW'(1)) begin
            r_state     <= DONE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b1;
            r_result    <= w_step;
            r_zero      <= is_zero(w_step);
          end else begin
            r_state     <= BUSY;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        DONE: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
        IDLE: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
